rx_window_sched: RTL and testbench
==================================

// Module: rx_window_sched
// PURPOSE
//  Receive-window scheduler for the radar RX path. Each rising edge of the IPP sync pulse
//  starts a sequence of up to NUM_WIN receive windows. Each window has its own start delay,
//  width and decimation rate. While a window is open, the block drives enable/rate of the
//  downstream strobe_gen instance; between windows it drops enable so strobe_gen reloads.
// PARAMETERS
//  NUM_WIN   2   number of windows per IPP, 1..4
//  CW        16  width of the timing counter, window start and window width fields
// PORTS
//  clock        in   1    system clock
//  reset        in   1    synchronous, active-high; clears all state and config registers
//  enable       in   1    run enable; low = sequencer idle, config retained
//  sync_in      in   1    IPP trigger, synchronous to clock, level; rising edge is used
//  cfg_we       in   1    config write strobe
//  cfg_addr     in   4    config register address
//  cfg_data     in   16   config write data
//  strobe_en    out  1    enable to strobe_gen; high only while a window is open
//  strobe_rate  out  8    rate to strobe_gen (divide ratio minus one)
//  win_idx      out  2    index of the current or next window
//  ipp_count    out  16   count of accepted syncs; wraps modulo 2^16
//  overrun      out  1    sticky; a sync arrived mid-sequence
//  dbus         out  16   debug: {state[1:0], win_idx, sync_in, strobe_en, overrun, 1'b0, tcnt[7:0]}
// BEHAVIOUR
//  Reset (or enable low): state=IDLE, tcnt=0, win_idx=0, strobe_en=0, strobe_rate=0.
//   ipp_count and overrun are cleared by reset only.
//  Config map: addr 3i+0 = start[i], 3i+1 = width[i], 3i+2 = rate[i] (low 8 bits), i<NUM_WIN.
//   addr 15 = control; bit0=1 clears overrun. Other addresses: write ignored.
//  Config writes go to shadow regs. Shadow regs are copied to the active table on an accepted
//   sync, so a mid-IPP write never alters the running sequence.
//  sync_rise = sync_in & ~sync_d (sync_d registered). Accepted in any state while enable=1.
//   On sync_rise: load active table, tcnt=0, win_idx=0, state=DELAY, ipp_count+1.
//   If state was DELAY/ACTIVE: also set overrun, drop strobe_en, restart at window 0.
//  States:
//   IDLE: wait for sync_rise.
//   DELAY: tcnt+1 per cycle (saturates at 2^CW-1).
//    If width[idx]==0: skip the window (idx+1, or DONE if idx is last); one cycle per skip.
//    Else if tcnt>=start[idx]: strobe_en<=1, strobe_rate<=rate[idx], rem<=width-1, go ACTIVE.
//   ACTIVE: tcnt+1. If rem==0: strobe_en<=0, then idx+1 -> DELAY, or DONE if idx==NUM_WIN-1.
//    Otherwise rem-1.
//   DONE: strobe_en=0, wait for sync_rise. win_idx holds the last index.
//  Latency: strobe_en rises S+1 cycles after the edge sampling sync_rise (S=start[0]).
//   It stays high exactly width[i] cycles.
//  Overlapping windows (start[i+1] < start[i]+width[i]): window i+1 opens on the first DELAY
//   cycle after window i closes. There is always a minimum 1-cycle strobe_en gap.
//  strobe_rate holds its last value while strobe_en=0.
//  sync_rise in the same cycle as cfg_we: the write lands in shadow first; the copy uses the
//   new value.
// STRUCTURE
//  Package rx_sched_pkg: state encodings (IDLE/DELAY/ACTIVE/DONE), address-map constants,
//   CTRL_ADDR=15.
//  Sub-module rx_win_regs: shadow + active register file with write decode and copy-on-sync.
//   The FSM/counters stay in the top level; strobe_gen is instantiated by the parent, not here.
// TESTING
//  1 NUM_WIN=2, start={10,40}, width={5,3}, rate={3,7}; sync pulse:
//    strobe_en high edges 11-15 with rate 3, then edges 41-43 with rate 7; DONE; ipp_count=1.
//  2 start[0]=0, width[0]=1: strobe_en high for exactly 1 cycle, 1 cycle after sync edge.
//  3 width[0]=0, start[1]=4, width[1]=2: window 0 skipped; strobe_en high 2 cycles from tcnt=4.
//  4 Second sync at tcnt=12 during window 0: overrun=1, strobe_en drops, sequence restarts,
//    ipp_count=2. Writing addr 15 with data 1 clears overrun.
//  5 Overlap start={0,2}, width={5,5}: window 1 opens 1 cycle after window 0 closes (1-cycle gap).
//  6 cfg write to start[0] mid-IPP: the current IPP is unchanged; the next sync uses the new value.
//    Reset or enable low mid-window: strobe_en=0 next cycle, state IDLE.

Source files
------------

// File: rtl/rx_sched_pkg.sv
// Shared types and constants for the RX receive-window scheduler:
// sequencer states, config address map and the field address helper.
package rx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned FIELDS_PER_WIN = 3;
  localparam int unsigned OFS_START      = 0;
  localparam int unsigned OFS_WIDTH      = 1;
  localparam int unsigned OFS_RATE       = 2;
  localparam int unsigned RATE_W         = 8;
  localparam logic [3:0]  CTRL_ADDR      = 4'd15;
  localparam int unsigned CTRL_CLR_OVR   = 0;

  // Register address of one field of one window.
  function automatic logic [3:0] win_addr(input int unsigned win, input int unsigned ofs);
    return 4'(win * FIELDS_PER_WIN + ofs);
  endfunction

endpackage

// File: rtl/rx_win_regs.sv
// Window configuration register file: host writes land in a shadow copy,
// which is transferred to the active table on every accepted IPP sync.
module rx_win_regs
  import rx_sched_pkg::*;
#(
  parameter int NUM_WIN = 2,
  parameter int CW      = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cfg_we,
  input  logic [3:0]                       cfg_addr,
  input  logic [15:0]                      cfg_data,
  input  logic                             load,
  output logic [NUM_WIN-1:0][CW-1:0]       act_start,
  output logic [NUM_WIN-1:0][CW-1:0]       act_width,
  output logic [NUM_WIN-1:0][RATE_W-1:0]   act_rate,
  output logic                             clr_overrun
);

  logic [NUM_WIN-1:0][CW-1:0]     sh_start, sh_start_nx;
  logic [NUM_WIN-1:0][CW-1:0]     sh_width, sh_width_nx;
  logic [NUM_WIN-1:0][RATE_W-1:0] sh_rate,  sh_rate_nx;

  // The active table copies the post-write shadow value, so a write coinciding
  // with the sync is already part of the sequence it starts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sh_start_nx = sh_start;
    sh_width_nx = sh_width;
    sh_rate_nx  = sh_rate;
    if (cfg_we) begin
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        if (cfg_addr == win_addr(i, OFS_START)) sh_start_nx[i] = CW'(cfg_data);
        if (cfg_addr == win_addr(i, OFS_WIDTH)) sh_width_nx[i] = CW'(cfg_data);
        if (cfg_addr == win_addr(i, OFS_RATE))  sh_rate_nx[i]  = cfg_data[RATE_W-1:0];
      end
    end
  end

  assign clr_overrun = cfg_we && (cfg_addr == CTRL_ADDR) && cfg_data[CTRL_CLR_OVR];

  always_ff @(posedge clock) begin
    // NOTE: the config tables are ordinary flops and are cleared by reset along with the state.
    if (reset) begin
      sh_start  <= '0;
      sh_width  <= '0;
      sh_rate   <= '0;
      act_start <= '0;
      act_width <= '0;
      act_rate  <= '0;
    end else begin
      sh_start <= sh_start_nx;
      sh_width <= sh_width_nx;
      sh_rate  <= sh_rate_nx;
      if (load) begin
        act_start <= sh_start_nx;
        act_width <= sh_width_nx;
        act_rate  <= sh_rate_nx;
      end
    end
  end

endmodule

// File: rtl/rx_window_sched.sv
// Receive-window scheduler: each IPP sync rising edge runs up to NUM_WIN windows,
// driving enable/rate of the downstream strobe generator while a window is open.
module rx_window_sched
  import rx_sched_pkg::*;
#(
  parameter int NUM_WIN = 2,
  parameter int CW      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        sync_in,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        strobe_en,
  output logic [7:0]  strobe_rate,
  output logic [1:0]  win_idx,
  output logic [15:0] ipp_count,
  output logic        overrun,
  output logic [15:0] dbus
);

  logic [NUM_WIN-1:0][CW-1:0]     act_start, act_width;
  logic [NUM_WIN-1:0][RATE_W-1:0] act_rate;
  logic                           clr_overrun;

  state_t              state_q, state_d;
  logic [CW-1:0]       tcnt_q, tcnt_d, tcnt_inc;
  logic [CW-1:0]       rem_q, rem_d;
  logic [1:0]          idx_q, idx_d;
  logic                en_q, en_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic                sync_d, sync_go, ovr_set, is_last;
  logic [CW-1:0]       cur_start, cur_width;
  logic [RATE_W-1:0]   cur_rate;

  assign sync_go  = enable & sync_in & ~sync_d;
  assign is_last  = (idx_q == 2'(NUM_WIN - 1));
  assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + CW'(1);

  rx_win_regs #(.NUM_WIN(NUM_WIN), .CW(CW)) u_regs (
    .clock       (clock),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .load        (sync_go),
    .act_start   (act_start),
    .act_width   (act_width),
    .act_rate    (act_rate),
    .clr_overrun (clr_overrun)
  );

  always_comb begin
    cur_start = '0;
    cur_width = '0;
    cur_rate  = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (idx_q == 2'(i)) begin
        cur_start = act_start[i];
        cur_width = act_width[i];
        cur_rate  = act_rate[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      en_q      <= 1'b0;
      rate_q    <= '0;
      sync_d    <= 1'b0;
      ipp_count <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      rate_q  <= rate_d;
      sync_d  <= sync_in;
      if (sync_go) ipp_count <= ipp_count + 16'd1;
      // A new overrun outranks a simultaneous clear request.
      if (ovr_set)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (sync_go) begin
      state_d = ST_DELAY;
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          if (cur_width == '0)         state_d = is_last ? ST_DONE : ST_DELAY;
          else if (tcnt_q >= cur_start) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: if (rem_q == '0)     state_d = is_last ? ST_DONE : ST_DELAY;
        default: ;
      endcase
    end
  end

  always_comb begin
    tcnt_d  = tcnt_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    en_d    = en_q;
    rate_d  = rate_q;
    ovr_set = 1'b0;
    if (!enable) begin
      tcnt_d = '0;
      rem_d  = '0;
      idx_d  = '0;
      en_d   = 1'b0;
      rate_d = '0;
    end else if (sync_go) begin
      tcnt_d  = '0;
      idx_d   = '0;
      en_d    = 1'b0;
      ovr_set = (state_q == ST_DELAY) || (state_q == ST_ACTIVE);
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          tcnt_d = tcnt_inc;
          if (cur_width == '0) begin
            if (!is_last) idx_d = idx_q + 2'd1;
          end else if (tcnt_q >= cur_start) begin
            en_d   = 1'b1;
            rate_d = cur_rate;
            rem_d  = cur_width - CW'(1);
          end
        end
        ST_ACTIVE: begin
          tcnt_d = tcnt_inc;
          if (rem_q == '0) begin
            en_d = 1'b0;
            if (!is_last) idx_d = idx_q + 2'd1;
          end else begin
            rem_d = rem_q - CW'(1);
          end
        end
        ST_DONE: en_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign strobe_en   = en_q;
  assign strobe_rate = rate_q;
  assign win_idx     = idx_q;
  assign dbus        = {state_q, idx_q, sync_in, en_q, overrun, 1'b0, tcnt_q[7:0]};

endmodule

// File: tb/tb_rx_window_sched.sv
// Self-checking bench for rx_window_sched: directed scenarios plus randomized IPPs
// compared every cycle against a timeline model built from the window rules.
module tb_rx_window_sched;

  localparam int NUM_WIN = 2;
  localparam int CW      = 16;
  localparam int KMAX    = 256;

  logic        clock = 1'b0;
  logic        reset, enable, sync_in, cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        strobe_en;
  logic [7:0]  strobe_rate;
  logic [1:0]  win_idx;
  logic [15:0] ipp_count;
  logic        overrun;
  logic [15:0] dbus;

  rx_window_sched #(.NUM_WIN(NUM_WIN), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sync_in     (sync_in),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .strobe_en   (strobe_en),
    .strobe_rate (strobe_rate),
    .win_idx     (win_idx),
    .ipp_count   (ipp_count),
    .overrun     (overrun),
    .dbus        (dbus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int hi_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: config tables plus a per-IPP timeline indexed by edges since the sync.
  int sh_start[NUM_WIN], sh_width[NUM_WIN], sh_rate[NUM_WIN];
  int act_start[NUM_WIN], act_width[NUM_WIN], act_rate[NUM_WIN];
  bit m_sync_d, m_seq, m_ovr;
  int m_ipp, m_k, m_done, m_rate_out;
  bit ex_en[KMAX];
  int ex_rate[KMAX], ex_idx[KMAX];
  bit e_en;
  int e_rate, e_idx, e_tcnt;

  task automatic build_timeline(input int r0);
    int cursor, open, ev;
    for (int k = 0; k < KMAX; k++) begin
      ex_en[k] = 1'b0; ex_rate[k] = r0; ex_idx[k] = 0;
    end
    cursor = 1;
    ev     = 1;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (act_width[i] == 0) begin
        ev     = cursor;
        cursor = cursor + 1;
      end else begin
        open = (act_start[i] + 1 > cursor) ? act_start[i] + 1 : cursor;
        for (int j = open; j < open + act_width[i] && j < KMAX; j++) ex_en[j] = 1'b1;
        for (int j = open; j < KMAX; j++) ex_rate[j] = act_rate[i];
        ev     = open + act_width[i];
        cursor = ev + 1;
      end
      if (i < NUM_WIN - 1)
        for (int j = ev; j < KMAX; j++) ex_idx[j] = i + 1;
    end
    m_done = ev;
  endtask

  task automatic model_edge();
    bit rise, clr;
    int a, kk;
    if (reset) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        sh_start[i] = 0; sh_width[i] = 0; sh_rate[i] = 0;
        act_start[i] = 0; act_width[i] = 0; act_rate[i] = 0;
      end
      m_sync_d = 0; m_seq = 0; m_ovr = 0; m_ipp = 0; m_k = 0; m_rate_out = 0;
    end else begin
      a = int'(cfg_addr);
      if (cfg_we && a < 3 * NUM_WIN) begin
        case (a % 3)
          0:       sh_start[a / 3] = int'(cfg_data);
          1:       sh_width[a / 3] = int'(cfg_data);
          default: sh_rate[a / 3]  = int'(cfg_data) % 256;
        endcase
      end
      clr      = cfg_we && (a == 15) && cfg_data[0];
      rise     = sync_in && !m_sync_d;
      m_sync_d = sync_in;
      if (clr) m_ovr = 0;
      if (!enable) begin
        m_seq      = 0;
        m_rate_out = 0;
      end else if (rise) begin
        if (m_seq && m_k < m_done) m_ovr = 1;
        m_ipp = (m_ipp + 1) % 65536;
        act_start = sh_start; act_width = sh_width; act_rate = sh_rate;
        build_timeline(m_rate_out);
        m_seq = 1;
        m_k   = 0;
      end else if (m_seq && m_k < 100000) begin
        m_k++;
      end
    end
    if (m_seq) begin
      kk     = (m_k < KMAX) ? m_k : KMAX - 1;
      e_en   = ex_en[kk];
      e_rate = ex_rate[kk];
      e_idx  = ex_idx[kk];
      e_tcnt = (m_k < m_done) ? m_k : m_done;
    end else begin
      e_en   = 1'b0;
      e_rate = m_rate_out;
      e_idx  = 0;
      e_tcnt = 0;
    end
    m_rate_out = e_rate;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check("strobe_en",   32'(strobe_en),   32'(e_en));
    check("strobe_rate", 32'(strobe_rate), 32'(e_rate));
    check("win_idx",     32'(win_idx),     32'(e_idx));
    check("ipp_count",   32'(ipp_count),   32'(m_ipp));
    check("overrun",     32'(overrun),     32'(m_ovr));
    check("dbus", 32'(dbus[13:0]), 32'({e_idx[1:0], sync_in, e_en, m_ovr, 1'b0, e_tcnt[7:0]}));
    if (strobe_en) hi_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = a[3:0];
    cfg_data = d[15:0];
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic load_cfg(input int s0, input int w0, input int r0,
                          input int s1, input int w1, input int r1);
    wr(0, s0); wr(1, w0); wr(2, r0);
    wr(3, s1); wr(4, w1); wr(5, r1);
  endtask

  task automatic sync_pulse();
    hi_cnt  = 0;
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sync_in = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    idle(2);
    reset  = 1'b0;
    enable = 1'b1;
    idle(2);

    // Two windows: high on edges 11-15 at rate 3 then 41-43 at rate 7.
    load_cfg(10, 5, 3, 40, 3, 7);
    sync_pulse();
    idle(10);
    check("t1_before_open", 32'(strobe_en), 32'd0);
    step();
    check("t1_open_edge11", 32'(strobe_en), 32'd1);
    check("t1_rate0", 32'(strobe_rate), 32'd3);
    idle(50);
    check("t1_high_cycles", 32'(hi_cnt), 32'd8);
    check("t1_ipp", 32'(ipp_count), 32'd1);
    check("t1_last_idx", 32'(win_idx), 32'd1);

    // Zero start, width 1: one high cycle on the first edge after the sync.
    load_cfg(0, 1, 5, 0, 0, 0);
    sync_pulse();
    step();
    check("t2_open_edge1", 32'(strobe_en), 32'd1);
    idle(10);
    check("t2_high_cycles", 32'(hi_cnt), 32'd1);

    // Window 0 skipped, window 1 opens at tcnt 4 for two cycles.
    load_cfg(0, 0, 9, 4, 2, 6);
    sync_pulse();
    idle(12);
    check("t3_high_cycles", 32'(hi_cnt), 32'd2);

    // Resync in the middle of window 0.
    load_cfg(10, 5, 3, 40, 3, 7);
    sync_pulse();
    idle(12);
    sync_pulse();
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_en_drop", 32'(strobe_en), 32'd0);
    check("t4_ipp", 32'(ipp_count), 32'd5);
    idle(60);
    wr(15, 1);
    check("t4_overrun_clr", 32'(overrun), 32'd0);

    // Overlapping windows keep a one-cycle gap.
    load_cfg(0, 5, 1, 2, 5, 2);
    sync_pulse();
    idle(20);
    check("t5_high_cycles", 32'(hi_cnt), 32'd10);

    // A mid-IPP start write only affects the next IPP.
    load_cfg(20, 3, 4, 30, 2, 8);
    sync_pulse();
    idle(5);
    wr(0, 2);
    idle(16);
    check("t6_old_start", 32'(strobe_en), 32'd1);
    idle(25);
    sync_pulse();
    idle(3);
    check("t6_new_start", 32'(strobe_en), 32'd1);
    idle(35);

    // Write coinciding with sync: new width 4 already in effect.
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'd4;
    sync_pulse();
    cfg_we = 1'b0;
    idle(40);
    check("t7_high_cycles", 32'(hi_cnt), 32'd6);

    // Enable low and reset in the middle of a window.
    load_cfg(2, 4, 9, 10, 2, 1);
    sync_pulse();
    idle(3);
    enable = 1'b0;
    step();
    check("t8_enable_low", 32'(strobe_en), 32'd0);
    enable = 1'b1;
    idle(3);
    sync_pulse();
    idle(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t8_reset_en", 32'(strobe_en), 32'd0);
    check("t8_reset_ipp", 32'(ipp_count), 32'd0);
    idle(2);

    // Randomized IPPs with stray writes, early resyncs and enable drops.
    for (int it = 0; it < 60; it++) begin
      load_cfg($urandom_range(0, 40), $urandom_range(0, 8), $urandom_range(0, 255),
               $urandom_range(0, 40), $urandom_range(0, 8), $urandom_range(0, 255));
      hi_cnt  = 0;
      sync_in = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      sync_in = 1'b0;
      for (int c = $urandom_range(2, 100); c > 0; c--) begin
        if ($urandom_range(0, 19) == 0) begin
          wr($urandom_range(0, 15), $urandom_range(0, 65535));
        end else if ($urandom_range(0, 49) == 0) begin
          enable = 1'b0;
          step();
          enable = 1'b1;
        end else begin
          step();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
